pwm_compare_stage: RTL
======================

Name: pwm_compare_stage

Overview:
Downstream consumer of the free-running mod-N counter value. It compares the incoming count against a double-buffered duty register and produces a registered PWM output, a one-cycle period-start strobe and a completed-period count. New duty values enter through a valid/ready handshake and take effect only at a period boundary, so no glitched or partial periods are produced.

Parameters:
CNT_W, 4, width of count_in and duty_in; must match the upstream counter width.
UPTO, 10, modulus of the upstream counter; count_in is in the range 0..UPTO-1.
DUTY_RST, 0, active duty value loaded at reset.
DEAD_CYC, 2, dead-time length in clocks; used only when PWM_DEADTIME_EN is defined; range 1..15.

Ports:
clk  input  1  rising-edge clock, shared with the upstream counter
rst  input  1  synchronous, active-high reset
count_in  input  CNT_W  counter value from the upstream stage
duty_in  input  CNT_W  requested duty, in high cycles per period
duty_valid  input  1  duty_in is valid
duty_ready  output  1  pending slot is empty; a duty value can be accepted
pwm_out  output  1  registered PWM output
period_start  output  1  one-cycle strobe, one cycle after count_in wraps
period_cnt  output  16  number of period starts since reset; wraps 0xFFFF->0
pwm_n_out  output  1  complementary output; exists only with PWM_DEADTIME_EN

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset values:
  - pwm_out=0, period_start=0, period_cnt=0
  - duty_act=DUTY_RST, pend_vld=0, so duty_ready=1
  - count_q={CNT_W{1'b1}}
  - pwm_n_out=0
- count_q holds a registered copy of count_in.
- wrap = (count_in < count_q).
  - Because count_q resets to all ones, the first count_in=0 after reset counts as a wrap.
  - With UPTO=1 the count is constantly 0, so only that first cycle is a wrap.
- Handshake:
  - duty_ready = ~pend_vld, driven combinationally from a register.
  - A transfer occurs when duty_valid && duty_ready. On a transfer, duty_pend<=duty_in and pend_vld<=1.
  - duty_valid while duty_ready=0 is ignored; the source must hold duty_in until the transfer.
- Duty commit on a wrap cycle with pend_vld=1: duty_act<=duty_pend and pend_vld<=0. duty_ready returns to 1 on the next cycle.
- Transfer and wrap in the same cycle: pend_vld was 0, so there is nothing to commit. The new value is stored in duty_pend and commits at the following wrap.
- Effective duty: duty_eff = (wrap && pend_vld) ? duty_pend : duty_act. A newly committed duty therefore applies from count 0 of the new period.
- PWM output: pwm_raw = (count_in < duty_eff); pwm_out <= pwm_raw.
  - Latency is one clock from count_in to pwm_out.
  - duty=0 gives pwm_out constantly 0.
  - duty>=UPTO gives pwm_out constantly 1, with no dip across the wrap.
- period_start <= wrap. When wrap=1, period_cnt <= period_cnt+1.
- Comparisons are unsigned at CNT_W bits; no extension is needed.
- Reset mid-operation discards any pending duty, restores DUTY_RST and clears all counters and outputs.
- rst has priority over every other event.

Optional Feature:
Macro PWM_DEADTIME_EN.
- Defined:
  - The pwm_n_out port exists.
  - A rising edge of the registered pwm_raw is delayed by DEAD_CYC clocks before pwm_out rises. Falling edges pass through immediately.
  - pwm_n_out is driven the same way from ~pwm_raw.
  - pwm_out and pwm_n_out are never both 1.
  - A raw high or low phase no longer than DEAD_CYC produces no pulse on the corresponding output.
  - Each output has its own dead-time counter of 4 bits, reset to 0.
- Not defined:
  - The pwm_n_out port is absent.
  - pwm_out is the registered pwm_raw.
  - DEAD_CYC is unused.

Test Plan:
All scenarios use CNT_W=4 and UPTO=10, with the upstream count cycling 0..9.
1. Reset: hold rst for 3 cycles -> pwm_out=0, period_start=0, period_cnt=0, duty_ready=1; count 0 after release -> period_start=1 one cycle later, period_cnt=1.
2. Steady duty: load duty 3 before the first wrap -> pwm_out high for 3 of every 10 cycles (one cycle after count 0..2); period_start every 10 cycles; period_cnt increments by 1 per period.
3. Mid-period update: duty 3 active; transfer 7 at count 5 -> duty_ready=0 from the next cycle; the current period stays 3-high; the next period is 7-high; duty_ready=1 the cycle after the wrap; duty_valid while not ready is ignored.
4. Boundaries: duty 0 -> pwm_out=0 across 3 periods; duty 10 and duty 15 -> pwm_out=1 continuously, including the cycles around the wrap.
5. Reset mid-period: duty 4 active, pending 8, rst asserted at count 6 -> after reset duty_act=DUTY_RST, no 8-wide period appears, period_cnt=0.
6. PWM_DEADTIME_EN with DEAD_CYC=2 and duty 5 -> pwm_out high 3 cycles and pwm_n_out high 3 cycles per period, 2 cycles both-low at each edge, never both high; duty 1 -> pwm_out never high.

Source files
------------

// File: rtl/pwm_compare_stage.sv
// Compares the upstream mod-UPTO count against a double-buffered duty value and emits
// a registered PWM, a period-start strobe and a period count. Optional dead time: PWM_DEADTIME_EN.
module pwm_compare_stage #(
    parameter int CNT_W    = 4,
    parameter int UPTO     = 10,
    parameter int DUTY_RST = 0,
    parameter int DEAD_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_in,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic [15:0]      period_cnt
`ifdef PWM_DEADTIME_EN
    ,
    output logic             pwm_n_out
`endif
);

    // Any duty at or above the modulus is a full-on period; clamp so the constant fits CNT_W+1 bits.
    localparam int              UPTO_SAT   = (UPTO < (1 << CNT_W)) ? UPTO : (1 << CNT_W);
    localparam logic [CNT_W:0]   UPTO_W     = (CNT_W + 1)'(UPTO_SAT);
    localparam logic [CNT_W-1:0] DUTY_RST_W = CNT_W'(DUTY_RST);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] duty_pend_q, duty_pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             raw_q, raw_d;
    logic             period_start_q, period_start_d;
    logic [15:0]      period_cnt_q, period_cnt_d;

    logic             wrap;
    logic             xfer;
    logic             commit;
    logic [CNT_W-1:0] duty_eff;

    always_comb begin
        wrap     = (count_in < count_q);
        xfer     = duty_valid && !pend_vld_q;
        commit   = wrap && pend_vld_q;
        duty_eff = commit ? duty_pend_q : duty_act_q;

        count_d        = count_in;
        duty_act_d     = duty_eff;
        duty_pend_d    = xfer ? duty_in : duty_pend_q;
        pend_vld_d     = commit ? 1'b0 : (xfer ? 1'b1 : pend_vld_q);
        raw_d          = ({1'b0, duty_eff} >= UPTO_W) || (count_in < duty_eff);
        period_start_d = wrap;
        period_cnt_d   = wrap ? period_cnt_q + 16'd1 : period_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q        <= '1;
            duty_act_q     <= DUTY_RST_W;
            duty_pend_q    <= '0;
            pend_vld_q     <= 1'b0;
            raw_q          <= 1'b0;
            period_start_q <= 1'b0;
            period_cnt_q   <= 16'd0;
        end else begin
            count_q        <= count_d;
            duty_act_q     <= duty_act_d;
            duty_pend_q    <= duty_pend_d;
            pend_vld_q     <= pend_vld_d;
            raw_q          <= raw_d;
            period_start_q <= period_start_d;
            period_cnt_q   <= period_cnt_d;
        end
    end

    assign duty_ready   = ~pend_vld_q;
    assign period_start = period_start_q;
    assign period_cnt   = period_cnt_q;

`ifdef PWM_DEADTIME_EN
    localparam logic [3:0] DEAD_W = 4'(DEAD_CYC);

    // Each counter measures how long its phase has lasted, saturating at the dead time.
    logic [3:0] dt_p_q, dt_p_d;
    logic [3:0] dt_n_q, dt_n_d;

    always_comb begin
        dt_p_d = 4'd0;
        dt_n_d = 4'd0;
        if (raw_q) begin
            dt_p_d = (dt_p_q == DEAD_W) ? dt_p_q : dt_p_q + 4'd1;
        end else begin
            dt_n_d = (dt_n_q == DEAD_W) ? dt_n_q : dt_n_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dt_p_q <= 4'd0;
            dt_n_q <= 4'd0;
        end else begin
            dt_p_q <= dt_p_d;
            dt_n_q <= dt_n_d;
        end
    end

    assign pwm_out   = raw_q && (dt_p_q == DEAD_W);
    assign pwm_n_out = !raw_q && (dt_n_q == DEAD_W);
`else
    // Dead time is not built in this configuration.
    logic [3:0] unused_dead_cyc;
    assign unused_dead_cyc = 4'(DEAD_CYC);
    assign pwm_out         = raw_q;
`endif

endmodule
